nonce_work_dbuf: RTL and testbench
==================================

# nonce_work_dbuf

Two-slot work buffer directly upstream of the x4 nonce core controller. Captures jobs (hash id, 96-bit message tail, 256-bit midstate) delivered by the SPI command decoder and holds them in two fixed slots. Publishes both slots plus `mark` / `mark_counter`, which tell the controller how many jobs are pending and which slot to dispatch next. Retires a job when the controller's `start` pulse is fed back as `take`.

## Interface
- `HID_W`, default 4: hash id width
- `MD_W`, default 96: message data width
- `H_W`, default 256: midstate width
- `clk`  in  1: clock
- `reset_n`  in  1: reset, asynchronous, active-low
- `wr_valid`  in  1: job offered this cycle
- `wr_hash_id`  in  HID_W: job hash id
- `wr_m_data`  in  MD_W: job message tail
- `wr_intial_h`  in  H_W: job midstate
- `wr_ready`  out  1: combinational, `mark_counter != 2`
- `take`  in  1: one-cycle pulse; controller dispatched the oldest job (its `start`)
- `flush`  in  1: one-cycle pulse; discard all pending jobs (clean-jobs / new block)
- `hash_id1`, `rx_m_data1`, `rx_intial_h1`  out  HID_W/MD_W/H_W: slot 1 contents
- `hash_id2`, `rx_m_data2`, `rx_intial_h2`  out  HID_W/MD_W/H_W: slot 2 contents
- `mark_counter`  out  2: pending jobs, 0..2
- `mark`  out  1: slot selector, encoding below
- `overflow`  out  1: sticky; write offered while full
- `underflow`  out  1: sticky; take while empty

## Operation
- Internal state: `count` (0..2, drives `mark_counter`), `rd_slot` (oldest pending slot: 0 = slot 1, 1 = slot 2), and `wr_slot` (next slot to write).
- `wr_slot` = `rd_slot` when `count == 0`, and `~rd_slot` when `count == 1`. It is undefined when full.
- `mark` encoding is registered and recomputed from the next-state values:
  - `count == 0`: 0
  - `count == 1`: 1 when `rd_slot == 0` (slot 1 holds the job), else 0
  - `count == 2`: 0 when `rd_slot == 0` (slot 1 is oldest), else 1
- Accepted write (`wr_valid && wr_ready`): the three fields load into slot `wr_slot`, and `count` increments.
- Write with `wr_ready = 0`: data is dropped, slots are unchanged, and `overflow` is set.
- `take` with `count > 0`: `count` decrements and `rd_slot` toggles. Slot contents are not cleared.
- `take` with `count == 0`: ignored, and `underflow` is set.
- Same-cycle `take` and accepted write (count 1 only, since a write needs count < 2 and a take needs count > 0):
  - the write goes to `~rd_slot`
  - `rd_slot` toggles
  - `count` stays 1
- Same-cycle `take` and write with count 2: the take retires the job, but the write is refused because `wr_ready` was 0 that cycle. `overflow` is set.
- `flush` has priority over `take`:
  - `count` <= 0 and `rd_slot` <= 0.
  - A write in the same cycle is then accepted into slot 1, giving `count` = 1 and `mark` = 1.
  - Slot contents are otherwise retained.
- `overflow` and `underflow` clear only on reset.

## Timing
- Reset values (asynchronous): all slot outputs 0, `mark_counter` 0, `mark` 0, `rd_slot` 0, `overflow` 0, `underflow` 0. `wr_ready` is 1 because count is 0.
- Write latency is one cycle. A write accepted at edge N is visible on slot outputs, `mark_counter` and `mark` after edge N.
- `take` latency is one cycle. The controller asserts `start` one cycle after sampling `mark` and `mark_counter`, and re-arms two cycles later, so the decremented count is seen before its next dispatch decision.
- A slot being written is never the slot named by `mark` for dispatch while `count == 1`, so writes never corrupt a job the controller may be selecting.
- Reset asserted mid-operation: all state returns to reset values immediately. A write in flight is lost.

## Test plan
- Reset, then write job A (hash_id 3) → next cycle: slot1 = A, `mark_counter` = 1, `mark` = 1, `wr_ready` = 1.
- Write A then B (hash_id 5) on consecutive cycles → slot2 = B, `mark_counter` = 2, `mark` = 0, `wr_ready` = 0.
- From the full state, pulse `take` → `mark_counter` = 1, `mark` = 0 (slot2 = B pending). Write C → C lands in slot1, count 2, `mark` = 1.
- With count 1 (A in slot1), pulse `take` and write B in the same cycle → slot2 = B, count 1, `mark` = 0.
- Full, offer write D → D dropped, slots unchanged, `overflow` = 1 and stays 1. `take` at count 0 → `underflow` = 1, count stays 0.
- With count 2, pulse `flush` with a simultaneous write E → slot1 = E, count 1, `mark` = 1. Slot2 keeps old data. Assert reset mid-sequence → all outputs return to 0.

Source files
------------

// File: rtl/nonce_work_dbuf.sv
// Two-slot job buffer between the SPI command decoder and the nonce core controller.
// Slots are fixed; count/rd_slot track pending jobs and mark tells the controller which slot to dispatch.
module nonce_work_dbuf #(
    parameter int HID_W = 4,
    parameter int MD_W  = 96,
    parameter int H_W   = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    input  logic [HID_W-1:0] wr_hash_id,
    input  logic [MD_W-1:0]  wr_m_data,
    input  logic [H_W-1:0]   wr_intial_h,
    output logic             wr_ready,
    input  logic             take,
    input  logic             flush,
    output logic [HID_W-1:0] hash_id1,
    output logic [MD_W-1:0]  rx_m_data1,
    output logic [H_W-1:0]   rx_intial_h1,
    output logic [HID_W-1:0] hash_id2,
    output logic [MD_W-1:0]  rx_m_data2,
    output logic [H_W-1:0]   rx_intial_h2,
    output logic [1:0]       mark_counter,
    output logic             mark,
    output logic             overflow,
    output logic             underflow
);

    logic [1:0] count, count_nx;
    logic       rd_slot, rd_nx;
    logic       mark_nx, ov_nx, uf_nx;
    logic       wr_acc, wr_slot, take_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= 2'd0;
            rd_slot      <= 1'b0;
            mark         <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            hash_id1     <= '0;
            rx_m_data1   <= '0;
            rx_intial_h1 <= '0;
            hash_id2     <= '0;
            rx_m_data2   <= '0;
            rx_intial_h2 <= '0;
        end else begin
            count     <= count_nx;
            rd_slot   <= rd_nx;
            mark      <= mark_nx;
            overflow  <= ov_nx;
            underflow <= uf_nx;
            if (wr_acc && !wr_slot) begin
                hash_id1     <= wr_hash_id;
                rx_m_data1   <= wr_m_data;
                rx_intial_h1 <= wr_intial_h;
            end
            if (wr_acc && wr_slot) begin
                hash_id2     <= wr_hash_id;
                rx_m_data2   <= wr_m_data;
                rx_intial_h2 <= wr_intial_h;
            end
        end
    end

    // A flush empties the buffer first, so a same-cycle write always fits into slot 1.
    always_comb begin
        count_nx = count;
        rd_nx    = rd_slot;
        ov_nx    = overflow;
        uf_nx    = underflow;
        take_ok  = 1'b0;
        wr_acc   = 1'b0;
        wr_slot  = 1'b0;
        if (flush) begin
            wr_acc   = wr_valid;
            wr_slot  = 1'b0;
            rd_nx    = 1'b0;
            count_nx = wr_valid ? 2'd1 : 2'd0;
        end else begin
            wr_acc  = wr_valid && (count != 2'd2);
            wr_slot = (count == 2'd0) ? rd_slot : ~rd_slot;
            take_ok = take && (count != 2'd0);
            if (wr_valid && count == 2'd2) ov_nx = 1'b1;
            if (take && count == 2'd0)     uf_nx = 1'b1;
            rd_nx    = rd_slot ^ take_ok;
            count_nx = count + {1'b0, wr_acc} - {1'b0, take_ok};
        end
        case (count_nx)
            2'd1:    mark_nx = ~rd_nx;
            2'd2:    mark_nx = rd_nx;
            default: mark_nx = 1'b0;
        endcase
    end

    always_comb begin
        wr_ready     = (count != 2'd2);
        mark_counter = count;
    end

endmodule

// File: tb/tb_nonce_work_dbuf.sv
// Self-checking bench for nonce_work_dbuf: directed vector table, reset check, then random traffic vs a job-queue model.
module tb_nonce_work_dbuf;
    localparam int HID_W = 4, MD_W = 96, H_W = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic [HID_W-1:0] wr_hash_id = '0;
    logic [MD_W-1:0]  wr_m_data = '0;
    logic [H_W-1:0]   wr_intial_h = '0;
    logic             wr_ready;
    logic             take = 1'b0;
    logic             flush = 1'b0;
    logic [HID_W-1:0] hash_id1, hash_id2;
    logic [MD_W-1:0]  rx_m_data1, rx_m_data2;
    logic [H_W-1:0]   rx_intial_h1, rx_intial_h2;
    logic [1:0]       mark_counter;
    logic             mark, overflow, underflow;

    nonce_work_dbuf #(.HID_W(HID_W), .MD_W(MD_W), .H_W(H_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_hash_id(wr_hash_id), .wr_m_data(wr_m_data),
        .wr_intial_h(wr_intial_h), .wr_ready(wr_ready),
        .take(take), .flush(flush),
        .hash_id1(hash_id1), .rx_m_data1(rx_m_data1), .rx_intial_h1(rx_intial_h1),
        .hash_id2(hash_id2), .rx_m_data2(rx_m_data2), .rx_intial_h2(rx_intial_h2),
        .mark_counter(mark_counter), .mark(mark),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       wv;
        logic [3:0] hid;
        logic       tk;
        logic       fl;
        logic [1:0] e_cnt;
        logic       e_mark;
        logic       e_rdy;
        logic [3:0] e_h1;
        logic [3:0] e_h2;
        logic       e_ov;
        logic       e_uf;
    } vec_t;

    vec_t vecs[12];

    // Model: slot contents plus a queue of pending slot indices, oldest first.
    logic [HID_W-1:0] m_hid[2];
    logic [MD_W-1:0]  m_md[2];
    logic [H_W-1:0]   m_h[2];
    int               pend[$];
    int               next_rd;
    logic             m_ov, m_uf;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hid[i] = '0; m_md[i] = '0; m_h[i] = '0;
        end
        pend.delete();
        next_rd = 0; m_ov = 0; m_uf = 0;
    endtask

    task automatic model_step(input logic wv, input logic [HID_W-1:0] hid,
                              input logic [MD_W-1:0] md, input logic [H_W-1:0] h,
                              input logic tk, input logic fl);
        int tgt;
        bit acc;
        if (fl) begin
            pend.delete();
            next_rd = 0;
            acc = wv;
            tgt = 0;
        end else begin
            tgt = (pend.size() == 0) ? next_rd : 1 - pend[0];
            acc = wv && (pend.size() < 2);
            if (wv && pend.size() == 2) m_ov = 1;
            if (tk) begin
                if (pend.size() > 0) begin
                    next_rd = 1 - pend[0];
                    void'(pend.pop_front());
                end else m_uf = 1;
            end
        end
        if (acc) begin
            m_hid[tgt] = hid; m_md[tgt] = md; m_h[tgt] = h;
            pend.push_back(tgt);
        end
    endtask

    function automatic logic model_mark();
        if (pend.size() == 0) return 1'b0;
        if (pend.size() == 1) return (pend[0] == 0);
        return (pend[0] == 1);
    endfunction

    task automatic check_vs_model(input string tag);
        chk({tag, " count"},    256'(mark_counter), 256'(pend.size()));
        chk({tag, " mark"},     256'(mark), 256'(model_mark()));
        chk({tag, " ready"},    256'(wr_ready), 256'(pend.size() != 2));
        chk({tag, " hid1"},     256'(hash_id1), 256'(m_hid[0]));
        chk({tag, " hid2"},     256'(hash_id2), 256'(m_hid[1]));
        chk({tag, " md1"},      256'(rx_m_data1), 256'(m_md[0]));
        chk({tag, " md2"},      256'(rx_m_data2), 256'(m_md[1]));
        chk({tag, " h1"},       rx_intial_h1, m_h[0]);
        chk({tag, " h2"},       rx_intial_h2, m_h[1]);
        chk({tag, " overflow"}, 256'(overflow), 256'(m_ov));
        chk({tag, " underflow"},256'(underflow), 256'(m_uf));
    endtask

    function automatic vec_t mk(logic wv, logic [3:0] hid, logic tk, logic fl, logic [1:0] c,
                                logic mk_, logic [3:0] h1, logic [3:0] h2, logic ov, logic uf);
        vec_t v;
        v.wv = wv; v.hid = hid; v.tk = tk; v.fl = fl; v.e_cnt = c; v.e_mark = mk_;
        v.e_rdy = (c != 2'd2); v.e_h1 = h1; v.e_h2 = h2; v.e_ov = ov; v.e_uf = uf;
        return v;
    endfunction

    initial begin
        //             wv hid   tk fl  cnt mark h1   h2   ov uf
        vecs[0]  = mk(1, 4'h3, 0, 0, 1, 1, 4'h3, 4'h0, 0, 0); // A -> slot1
        vecs[1]  = mk(1, 4'h5, 0, 0, 2, 0, 4'h3, 4'h5, 0, 0); // B -> slot2, full
        vecs[2]  = mk(0, 4'h0, 1, 0, 1, 0, 4'h3, 4'h5, 0, 0); // take A, B pending
        vecs[3]  = mk(1, 4'h7, 0, 0, 2, 1, 4'h7, 4'h5, 0, 0); // C -> slot1, B oldest
        vecs[4]  = mk(1, 4'h9, 0, 0, 2, 1, 4'h7, 4'h5, 1, 0); // D dropped while full
        vecs[5]  = mk(0, 4'h0, 1, 0, 1, 1, 4'h7, 4'h5, 1, 0); // take B, C pending
        vecs[6]  = mk(1, 4'hB, 1, 0, 1, 0, 4'h7, 4'hB, 1, 0); // take C + write -> slot2
        vecs[7]  = mk(0, 4'h0, 1, 0, 0, 0, 4'h7, 4'hB, 1, 0); // empty
        vecs[8]  = mk(0, 4'h0, 1, 0, 0, 0, 4'h7, 4'hB, 1, 1); // take while empty
        vecs[9]  = mk(1, 4'h2, 0, 0, 1, 1, 4'h2, 4'hB, 1, 1); // rd_slot back at slot1
        vecs[10] = mk(1, 4'h4, 0, 0, 2, 0, 4'h2, 4'h4, 1, 1);
        vecs[11] = mk(1, 4'h6, 1, 1, 1, 1, 4'h6, 4'h4, 1, 1); // flush + write -> slot1

        #12;
        chk("reset count", 256'(mark_counter), 256'(0));
        chk("reset mark",  256'(mark), 256'(0));
        chk("reset ready", 256'(wr_ready), 256'(1));
        chk("reset hid1",  256'(hash_id1), 256'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_valid    = vecs[i].wv;
            wr_hash_id  = vecs[i].hid;
            wr_m_data   = {24{vecs[i].hid}};
            wr_intial_h = {64{vecs[i].hid}};
            take        = vecs[i].tk;
            flush       = vecs[i].fl;
            @(posedge clk); #1;
            chk($sformatf("v%0d count", i), 256'(mark_counter), 256'(vecs[i].e_cnt));
            chk($sformatf("v%0d mark", i),  256'(mark), 256'(vecs[i].e_mark));
            chk($sformatf("v%0d ready", i), 256'(wr_ready), 256'(vecs[i].e_rdy));
            chk($sformatf("v%0d hid1", i),  256'(hash_id1), 256'(vecs[i].e_h1));
            chk($sformatf("v%0d hid2", i),  256'(hash_id2), 256'(vecs[i].e_h2));
            chk($sformatf("v%0d md1", i),   256'(rx_m_data1), 256'({24{vecs[i].e_h1}}));
            chk($sformatf("v%0d h2", i),    rx_intial_h2, {64{vecs[i].e_h2}});
            chk($sformatf("v%0d overflow", i),  256'(overflow), 256'(vecs[i].e_ov));
            chk($sformatf("v%0d underflow", i), 256'(underflow), 256'(vecs[i].e_uf));
        end

        // Reset asserted mid-operation with a write in flight.
        @(negedge clk);
        wr_valid = 1'b1; wr_hash_id = 4'hE; take = 1'b0; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_vs_model("midreset");
        @(posedge clk); #1;
        check_vs_model("midreset held");
        @(negedge clk);
        wr_valid = 1'b0;
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic             wv, tk, fl;
            logic [HID_W-1:0] hid;
            logic [MD_W-1:0]  md;
            logic [H_W-1:0]   h;
            @(negedge clk);
            wv  = ($urandom_range(0, 99) < 55);
            tk  = ($urandom_range(0, 99) < 35);
            fl  = ($urandom_range(0, 99) < 6);
            hid = HID_W'($urandom);
            md  = {$urandom, $urandom, $urandom};
            h   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wr_valid = wv; wr_hash_id = hid; wr_m_data = md; wr_intial_h = h;
            take = tk; flush = fl;
            model_step(wv, hid, md, h, tk, fl);
            @(posedge clk); #1;
            check_vs_model($sformatf("rnd%0d", n));
        end

        @(negedge clk);
        wr_valid = 1'b0; take = 1'b0; flush = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
